md_sequencer: RTL and testbench

Multiply/divide resource controller for the EX stage of the 5-stage pipeline.
- Accepts one HI/LO operation per issue, computes the result, and holds the HI/LO architectural registers.
- Models fixed multi-cycle latency with a counter-driven FSM.
- Exports busy so the hazard unit stalls dependent md instructions (mfhi/mflo/mult/div/mthi/mtlo) until the result commits.

---
 rtl/md_sequencer_pkg.sv | 25 ++
 rtl/md_sequencer_if.sv | 14 +
 rtl/md_arith.sv | 45 ++++
 rtl/md_sequencer.sv | 79 +++++++
 tb/tb_md_sequencer.sv | 125 ++++++++++++
 5 files changed

// File: rtl/md_sequencer_pkg.sv
// md_sequencer_pkg: op encodings, FSM states and op-class helpers shared by md_sequencer and md_arith.
// Optional: MD_MADD_EN makes MADD/MADDU/MSUB/MSUBU multiply-class ops; otherwise they are undefined.
package md_sequencer_pkg;
   localparam logic [3:0] MD_MULT  = 4'd0;
   localparam logic [3:0] MD_MULTU = 4'd1;
   localparam logic [3:0] MD_DIV   = 4'd2;
   localparam logic [3:0] MD_DIVU  = 4'd3;
   localparam logic [3:0] MD_MTHI  = 4'd4;
   localparam logic [3:0] MD_MTLO  = 4'd5;
   localparam logic [3:0] MD_MADD  = 4'd6;
   localparam logic [3:0] MD_MADDU = 4'd7;
   localparam logic [3:0] MD_MSUB  = 4'd8;
   localparam logic [3:0] MD_MSUBU = 4'd9;
   typedef enum logic {S_IDLE, S_BUSY} md_state_e;
   function automatic logic is_mul_op(input logic [3:0] op);
`ifdef MD_MADD_EN
      return op inside {MD_MULT, MD_MULTU, MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU};
`else
      return op inside {MD_MULT, MD_MULTU};
`endif
   endfunction
   function automatic logic is_div_op(input logic [3:0] op);
      return op inside {MD_DIV, MD_DIVU};
   endfunction
endpackage

// File: rtl/md_sequencer_if.sv
// md_sequencer_if: issue/result bundle between EX and the HI/LO unit.
// master (EX side) drives start/op/rs_data/rt_data; slave (md_sequencer) drives busy/done/hi/lo.
interface md_sequencer_if;
   logic        start;
   logic [3:0]  op;
   logic [31:0] rs_data;
   logic [31:0] rt_data;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;
   modport master (output start, op, rs_data, rt_data, input busy, done, hi, lo);
   modport slave (input start, op, rs_data, rt_data, output busy, done, hi, lo);
endinterface

// File: rtl/md_arith.sv
// md_arith: combinational 64-bit HI/LO result generator.
// Ports: op/rs/rt operands, hi/lo accumulator in; res_hi/res_lo result and div0 (divide by zero) out.
// Optional: MD_MADD_EN adds the multiply-accumulate/subtract results.
module md_arith
   import md_sequencer_pkg::*;
(
   input  logic [3:0]  op,
   input  logic [31:0] rs,
   input  logic [31:0] rt,
   input  logic [31:0] hi,
   input  logic [31:0] lo,
   output logic [31:0] res_hi,
   output logic [31:0] res_lo,
   output logic        div0
);
   logic [63:0] acc, prod_s, prod_u, res;
   logic signed [32:0] dvd_s, dvs_s;
   logic [31:0] dvs_u, quo_s, rem_s;
   always_comb begin
      div0 = is_div_op(op) && rt == 32'd0;
      acc = {hi, lo};
      prod_s = $signed({{32{rs[31]}}, rs}) * $signed({{32{rt[31]}}, rt});
      prod_u = {32'd0, rs} * {32'd0, rt};
      // 33-bit signed divide so 0x80000000 / -1 wraps to 0x80000000 instead of overflowing
      dvd_s = {rs[31], rs};
      dvs_s = (rt == 32'd0) ? 33'sd1 : {rt[31], rt};
      dvs_u = (rt == 32'd0) ? 32'd1 : rt;
      quo_s = 32'(dvd_s / dvs_s);
      rem_s = 32'(dvd_s % dvs_s);
      case (op)
         MD_MULT:  res = prod_s;
         MD_MULTU: res = prod_u;
         MD_DIV:   res = {rem_s, quo_s};
         MD_DIVU:  res = {rs % dvs_u, rs / dvs_u};
`ifdef MD_MADD_EN
         MD_MADD:  res = acc + prod_s;
         MD_MADDU: res = acc + prod_u;
         MD_MSUB:  res = acc - prod_s;
         MD_MSUBU: res = acc - prod_u;
`endif
         default:  res = acc;
      endcase
      {res_hi, res_lo} = res;
   end
endmodule

// File: rtl/md_sequencer.sv
// md_sequencer: multi-cycle mult/div controller holding the HI/LO registers.
// Ports: clk; reset (async, active-low); md (md_sequencer_if.slave: start/op/rs_data/rt_data in,
// busy/done/hi/lo out). Optional: MD_MADD_EN enables MADD/MADDU/MSUB/MSUBU.
module md_sequencer
   import md_sequencer_pkg::*;
#(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input logic          clk,
   input logic          reset,
   md_sequencer_if.slave md
);
   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW = $clog2(MAX_CYCLES + 1);
   md_state_e state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [31:0] res_hi_q, res_hi_d, res_lo_q, res_lo_d, hi_q, hi_d, lo_q, lo_d;
   logic div0_q, div0_d, done_q, done_d;
   logic [31:0] arith_hi, arith_lo;
   logic arith_div0;
   md_arith u_arith (
      .op(md.op), .rs(md.rs_data), .rt(md.rt_data), .hi(hi_q), .lo(lo_q),
      .res_hi(arith_hi), .res_lo(arith_lo), .div0(arith_div0)
   );
   // Result is captured at issue; the counter only models latency down to the commit edge.
   always_comb begin
      state_d = state_q;
      cnt_d = cnt_q;
      res_hi_d = res_hi_q;
      res_lo_d = res_lo_q;
      div0_d = div0_q;
      hi_d = hi_q;
      lo_d = lo_q;
      done_d = 1'b0;
      if (state_q == S_IDLE) begin
         if (md.start && (is_mul_op(md.op) || is_div_op(md.op))) begin
            res_hi_d = arith_hi;
            res_lo_d = arith_lo;
            div0_d = arith_div0;
            cnt_d = is_div_op(md.op) ? CW'(DIV_CYCLES - 1) : CW'(MULT_CYCLES - 1);
            state_d = S_BUSY;
         end else if (md.start && md.op == MD_MTHI) hi_d = md.rs_data;
         else if (md.start && md.op == MD_MTLO) lo_d = md.rs_data;
      end else if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
      else begin
         state_d = S_IDLE;
         done_d = 1'b1;
         // divide by zero still completes but leaves HI/LO untouched
         hi_d = div0_q ? hi_q : res_hi_q;
         lo_d = div0_q ? lo_q : res_lo_q;
      end
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cnt_q <= '0;
         res_hi_q <= '0;
         res_lo_q <= '0;
         div0_q <= 1'b0;
         hi_q <= '0;
         lo_q <= '0;
         done_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         res_hi_q <= res_hi_d;
         res_lo_q <= res_lo_d;
         div0_q <= div0_d;
         hi_q <= hi_d;
         lo_q <= lo_d;
         done_q <= done_d;
      end
   end
   assign md.busy = (state_q == S_BUSY);
   assign md.done = done_q;
   assign md.hi = hi_q;
   assign md.lo = lo_q;
endmodule

// File: tb/tb_md_sequencer.sv
// tb_md_sequencer: directed stimulus with a done-driven scoreboard for md_sequencer.
module tb_md_sequencer;
   import md_sequencer_pkg::*;
   logic clk = 1'b0;
   logic reset;
   int total = 0;
   int bad = 0;
   int n;
   logic [63:0] exp_q[$];
   logic [63:0] mon_e;
   md_sequencer_if m();
   md_sequencer #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (.clk(clk), .reset(reset), .md(m));
   always #5 clk = ~clk;
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask
   always @(posedge clk) begin
      #1;
      if (m.done === 1'b1) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL done_unexpected: got hilo %h want no done", {m.hi, m.lo});
         end else begin
            mon_e = exp_q.pop_front();
            if ({m.hi, m.lo} !== mon_e) begin
               bad++;
               $display("FAIL commit: got %h want %h", {m.hi, m.lo}, mon_e);
            end
         end
      end
   end
   task automatic issue(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt);
      @(negedge clk);
      m.start = 1'b1;
      m.op = op;
      m.rs_data = rs;
      m.rt_data = rt;
      @(negedge clk);
      m.start = 1'b0;
   endtask
   task automatic busy_len(output int c);
      c = 0;
      while (m.busy === 1'b1 && c < 100) begin
         c++;
         @(negedge clk);
      end
   endtask
   task automatic run(input string name, input logic [3:0] op, input logic [31:0] rs,
                      input logic [31:0] rt, input int cycles, input logic [63:0] exp);
      int c;
      exp_q.push_back(exp);
      issue(op, rs, rt);
      busy_len(c);
      chk({name, "_busy"}, 64'(c), 64'(cycles));
   endtask
   initial begin
      m.start = 1'b0;
      m.op = 4'd0;
      m.rs_data = 32'd0;
      m.rt_data = 32'd0;
      reset = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_busy", 64'(m.busy), 64'd0);
      chk("rst_done", 64'(m.done), 64'd0);
      chk("rst_hilo", {m.hi, m.lo}, 64'd0);
      reset = 1'b1;
      run("mult", MD_MULT, 32'hFFFFFFFF, 32'd2, 5, 64'hFFFFFFFF_FFFFFFFE);
      run("multu", MD_MULTU, 32'hFFFFFFFF, 32'd2, 5, 64'h00000001_FFFFFFFE);
      run("div", MD_DIV, 32'hFFFFFFF9, 32'd2, 10, 64'hFFFFFFFF_FFFFFFFD);
      run("divu0", MD_DIVU, 32'd7, 32'd0, 10, 64'hFFFFFFFF_FFFFFFFD);
      issue(MD_MTHI, 32'h12345678, 32'd0);
      chk("mthi_busy", 64'(m.busy), 64'd0);
      chk("mthi_hilo", {m.hi, m.lo}, 64'h12345678_FFFFFFFD);
      issue(MD_MTLO, 32'hCAFEF00D, 32'd0);
      chk("mtlo_busy", 64'(m.busy), 64'd0);
      chk("mtlo_hilo", {m.hi, m.lo}, 64'h12345678_CAFEF00D);
      issue(4'hF, 32'h55555555, 32'd1);
      chk("undef_busy", 64'(m.busy), 64'd0);
      chk("undef_hilo", {m.hi, m.lo}, 64'h12345678_CAFEF00D);
      exp_q.push_back(64'h00000000_80000000);
      issue(MD_DIV, 32'h80000000, 32'hFFFFFFFF);
      issue(MD_MULT, 32'd3, 32'd3);
      busy_len(n);
      chk("div_ign_busy", 64'(n), 64'd8);
      repeat (3) @(negedge clk);
      chk("div_ign_hilo", {m.hi, m.lo}, 64'h00000000_80000000);
      issue(MD_MTHI, 32'd0, 32'd0);
      issue(MD_MTLO, 32'hFFFFFFFF, 32'd0);
`ifdef MD_MADD_EN
      run("maddu", MD_MADDU, 32'd1, 32'd1, 5, 64'h00000001_00000000);
`else
      issue(MD_MADDU, 32'd1, 32'd1);
      chk("maddu_off_busy", 64'(m.busy), 64'd0);
      repeat (6) @(negedge clk);
      chk("maddu_off_hilo", {m.hi, m.lo}, 64'h00000000_FFFFFFFF);
`endif
      issue(MD_MULT, 32'd3, 32'd3);
      repeat (2) @(negedge clk);
      chk("pre_rst_busy", 64'(m.busy), 64'd1);
      #2 reset = 1'b0;
      #1;
      chk("arst_busy", 64'(m.busy), 64'd0);
      chk("arst_hilo", {m.hi, m.lo}, 64'd0);
      @(negedge clk);
      reset = 1'b1;
      repeat (12) @(negedge clk);
      chk("post_rst_busy", 64'(m.busy), 64'd0);
      chk("post_rst_hilo", {m.hi, m.lo}, 64'd0);
      run("mult_neg", MD_MULT, 32'd7, 32'hFFFFFFFD, 5, 64'hFFFFFFFF_FFFFFFEB);
      repeat (3) @(negedge clk);
      chk("sb_empty", 64'(exp_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
   initial begin
      #200000;
      $display("FAIL watchdog: got no finish want finish");
      $fatal(1, "timeout");
   end
endmodule
